mips_mmio_bridge: RTL and testbench
===================================

Name: mips_mmio_bridge

Overview:
- Sits directly downstream of the single-cycle MIPS core's data-memory port (memwrite, aluout, writedata, readdata), between the core and data memory.
- Decodes the core's data address and steers each access either to data memory or to a small memory-mapped I/O region.
- The I/O region holds a buffered output channel (FIFO drained through a valid/ready handshake) and a free-running cycle counter.
- Reads are combinational so the single-cycle core never stalls; all state updates occur on the rising clk edge.

Parameters:
- DEPTH, 8: output FIFO entries; power of two, minimum 2.
- ODW, 8: output data width; writedata[ODW-1:0] is pushed.
- IO_BASE, 32'hFFFF0000: base address of the I/O region; upper 16 bits are matched.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- cpu_addr, input, 32: data address (core aluout).
- cpu_memwrite, input, 1: store strobe from the core.
- cpu_writedata, input, 32: store data.
- cpu_readdata, output, 32: load data returned to the core.
- dmem_we, output, 1: write enable to data memory.
- dmem_rd, input, 32: data memory read data.
- out_data, output, ODW: FIFO head.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts the head.

Behaviour:
- Address decode:
  - is_io = (cpu_addr[31:16] == IO_BASE[31:16]).
  - Non-I/O: dmem_we = cpu_memwrite; cpu_readdata = dmem_rd.
  - I/O: dmem_we = 0.
- I/O register map (offsets use cpu_addr[15:0]; other offsets read 0, writes ignored):
  - 0x0000 TXDATA, write-only, reads 0. A store pushes cpu_writedata[ODW-1:0].
  - 0x0004 STATUS, read layout:
    - [31] overflow (sticky)
    - [30] full
    - [29] empty
    - [$clog2(DEPTH):0] count
    - all other bits 0
  - 0x0004 STATUS, write: bit0 = 1 clears overflow; other bits ignored.
  - 0x0008 CYCLE: read returns the counter; any store sets it to 0.
- Read timing: I/O reads are combinational from current registered state. A read in the same cycle as a push/pop shows pre-edge values.
- FIFO:
  - Circular buffer with read/write pointers plus count.
  - push = is_io & cpu_memwrite & (offset == 0).
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rptr], registered storage; a pushed word appears on out_data one cycle after the push edge when the FIFO was empty.
- FIFO boundary cases:
  - Push while full, no pop: data dropped, pointers unchanged, overflow set to 1 next cycle.
  - Push while full with a pop in the same cycle: push accepted, count unchanged, no overflow.
  - Push and pop while 0 < count < DEPTH: both take effect, count unchanged.
  - Pop while empty: impossible (out_valid = 0).
  - Pointers wrap DEPTH-1 -> 0.
  - Overflow set and clear in the same cycle: set wins.
- Handshake: out_data and out_valid stay stable while out_valid = 1 and out_ready = 0.
- Cycle counter:
  - Increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
  - A store to CYCLE has priority over the increment; value is 0 on the next edge.
- Reset (synchronous, active-high):
  - count = 0, rptr = wptr = 0, overflow = 0, cycle = 0; out_valid = 0.
  - FIFO storage is not reset.
  - Reset asserted mid-stream discards all buffered entries.
- Combinational outputs (dmem_we, cpu_readdata) follow inputs regardless of reset. During reset, the registers they read hold reset values after the first edge.

Optional Feature:
- Macro: MMIO_CYCLE_COUNTER_EN.
- Defined: CYCLE register implemented as above.
- Undefined: no counter flops; CYCLE reads 32'h0 and stores to it are ignored. All other behaviour is identical.

Decomposition:
- Package mmio_pkg holds:
  - IO region match constant
  - offsets TXDATA_OFS, STATUS_OFS, CYCLE_OFS
  - STATUS bit positions (ST_OVF = 31, ST_FULL = 30, ST_EMPTY = 29)
  - STATUS clear-bit constant
- One sub-module: mmio_sync_fifo (parameters DEPTH, ODW).
  - Ports: clk, reset, push, din, pop, dout, count, full, empty.
  - The bridge holds decode, overflow, counter and readdata mux.

Test Plan:
- Non-I/O pass-through: store to 0x00000054 -> dmem_we = 1; load with dmem_rd = 32'hDEADBEEF -> cpu_readdata = 32'hDEADBEEF.
- I/O isolation: store to 0xFFFF0000 -> dmem_we = 0. Load from 0xFFFF0010 -> cpu_readdata = 0.
- Push/drain: out_ready = 0; push 0x41, 0x42, 0x43 -> STATUS count = 3, empty = 0. Then set out_ready = 1 -> out_data sequence 0x41, 0x42, 0x43, after which out_valid = 0.
- Full/overflow:
  - Push 9 bytes with DEPTH = 8, out_ready = 0 -> full = 1, overflow = 1, 9th byte absent from drained data.
  - Store 1 to STATUS -> overflow = 0.
  - Repeat full plus simultaneous push and pop -> count stays 8, overflow stays 0.
- Cycle counter:
  - 10 cycles after reset, read CYCLE -> 10 (±1 per sampling edge, checked exactly against the bench's own counter).
  - Store to CYCLE -> reads 1 one cycle later.
  - Force wrap by preloading via bench hierarchy to 32'hFFFFFFFF -> next value 0.
- Reset mid-operation: with 5 entries queued and overflow = 1, pulse reset for 1 cycle -> out_valid = 0, STATUS = {overflow 0, empty 1, count 0}, CYCLE = 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared decode constants and the STATUS word layout for the MIPS MMIO bridge.
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DEF   = 32'hFFFF_0000;
  localparam int          IO_MATCH_LSB  = 16;

  localparam logic [15:0] TXDATA_OFS    = 16'h0000;
  localparam logic [15:0] STATUS_OFS    = 16'h0004;
  localparam logic [15:0] CYCLE_OFS     = 16'h0008;

  localparam int          ST_OVF        = 31;
  localparam int          ST_FULL       = 30;
  localparam int          ST_EMPTY      = 29;
  localparam int          STATUS_CLR_BIT = 0;

  // Count sits in the low bits; flags overwrite the top three.
  function automatic logic [31:0] status_word(input logic        ovf,
                                              input logic        full,
                                              input logic        empty,
                                              input logic [31:0] cnt);
    logic [31:0] w;
    w           = cnt;
    w[ST_OVF]   = ovf;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Circular-buffer FIFO; push is dropped when full unless a pop frees the slot the same edge.
// Head is read straight from storage, so a word is visible one cycle after its push edge.
module mmio_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int ODW   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ODW-1:0]           din,
  input  logic                     pop,
  output logic [ODW-1:0]           dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ODW-1:0] mem [DEPTH];
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  wptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_mmio_bridge.sv
// Steers core data accesses to dmem or an MMIO block (TX FIFO, STATUS, CYCLE); reads are combinational.
// MMIO_CYCLE_COUNTER_EN enables the CYCLE counter flops; otherwise CYCLE reads 0 and ignores stores.
module mips_mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter int          ODW     = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    cpu_addr,
  input  logic           cpu_memwrite,
  input  logic [31:0]    cpu_writedata,
  output logic [31:0]    cpu_readdata,
  output logic           dmem_we,
  input  logic [31:0]    dmem_rd,
  output logic [ODW-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                    is_io;
  logic [15:0]             offset;
  logic                    io_wr;
  logic                    push;
  logic                    pop;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    overflow;
  logic                    ovf_set;
  logic                    ovf_clr;
  logic [31:0]             status;
  logic [31:0]             cycle_val;
  logic                    unused_wdata;

  assign is_io   = (cpu_addr[31:IO_MATCH_LSB] == IO_BASE[31:IO_MATCH_LSB]);
  assign offset  = cpu_addr[IO_MATCH_LSB-1:0];
  assign io_wr   = is_io & cpu_memwrite;
  assign dmem_we = cpu_memwrite & ~is_io;

  assign push      = io_wr & (offset == TXDATA_OFS);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  assign unused_wdata = ^cpu_writedata;

  mmio_sync_fifo #(
    .DEPTH (DEPTH),
    .ODW   (ODW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cpu_writedata[ODW-1:0]),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full FIFO is only lost when no pop makes room on the same edge.
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = io_wr & (offset == STATUS_OFS) & cpu_writedata[STATUS_CLR_BIT];

  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycle;
  logic        cycle_wr;

  assign cycle_wr = io_wr & (offset == CYCLE_OFS);

  always_ff @(posedge clk) begin
    if (reset)         cycle <= '0;
    else if (cycle_wr) cycle <= '0;
    else               cycle <= cycle + 32'd1;
  end

  assign cycle_val = cycle;
`else
  assign cycle_val = '0;
`endif

  assign status = status_word(overflow, fifo_full, fifo_empty, 32'(fifo_count));

  always_comb begin
    cpu_readdata = dmem_rd;
    if (is_io) begin
      case (offset)
        STATUS_OFS: cpu_readdata = status;
        CYCLE_OFS:  cpu_readdata = cycle_val;
        default:    cpu_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Directed plus randomized bench for mips_mmio_bridge against a queue-based reference model.
module tb_mips_mmio_bridge;

  localparam int DEPTH = 8;
  localparam int ODW   = 8;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_memwrite;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        dmem_we;
  logic [31:0] dmem_rd;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  mips_mmio_bridge #(
    .DEPTH   (DEPTH),
    .ODW     (ODW),
    .IO_BASE (32'hFFFF_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .dmem_we       (dmem_we),
    .dmem_rd       (dmem_rd),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic [31:0] m_cyc;
  bit          m_known = 0;

  logic [31:0] last_rd;
  logic        last_we;
  logic        last_valid;
  logic [7:0]  last_data;

`ifdef MMIO_CYCLE_COUNTER_EN
  localparam bit HAS_CYC = 1'b1;
`else
  localparam bit HAS_CYC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] dm);
    logic [31:0] r;
    if (a[31:16] != 16'hFFFF) return dm;
    r = 32'h0;
    case (a[15:0])
      16'h0004: begin
        r = 32'(m_q.size());
        r[31] = m_ovf;
        r[30] = (m_q.size() == DEPTH);
        r[29] = (m_q.size() == 0);
      end
      16'h0008: r = HAS_CYC ? m_cyc : 32'h0;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  // One core cycle: drive, check combinational view at negedge, advance model at posedge.
  task automatic cyc(input logic r, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic rdy, input logic [31:0] dm);
    bit io;
    bit push;
    bit pop;
    reset = r; cpu_addr = a; cpu_memwrite = w; cpu_writedata = d;
    out_ready = rdy; dmem_rd = dm;
    io = (a[31:16] == 16'hFFFF);
    @(negedge clk);
    chk("dmem_we", {31'b0, dmem_we}, {31'b0, w & ~io});
    if (m_known) begin
      chk("readdata", cpu_readdata, exp_read(a, dm));
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("out_data", {24'b0, out_data}, {24'b0, m_q[0]});
    end else if (!io) begin
      chk("readdata_pt", cpu_readdata, dm);
    end
    last_rd = cpu_readdata; last_we = dmem_we;
    last_valid = out_valid; last_data = out_data;
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_ovf = 1'b0; m_cyc = 32'h0; m_known = 1;
    end else if (m_known) begin
      push = io && w && (a[15:0] == 16'h0000);
      pop  = (m_q.size() != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (io && w && a[15:0] == 16'h0004 && d[0]) m_ovf = 1'b0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      if (io && w && a[15:0] == 16'h0008) m_cyc = 32'h0;
      else m_cyc = m_cyc + 32'd1;
    end
    #1;
  endtask

  localparam logic [31:0] TX = 32'hFFFF_0000;
  localparam logic [31:0] ST = 32'hFFFF_0004;
  localparam logic [31:0] CY = 32'hFFFF_0008;

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_memwrite = 1'b0; cpu_writedata = '0;
    dmem_rd = '0; out_ready = 1'b0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("rst_status", last_rd, 32'h2000_0000);
    chk("rst_valid", {31'b0, last_valid}, 32'h0);

    // Pass-through and I/O isolation
    cyc(0, 32'h0000_0054, 1, 32'h1234, 0, 0);
    chk("pt_we", {31'b0, last_we}, 32'h1);
    cyc(0, 32'h0000_0054, 0, 0, 0, 32'hDEAD_BEEF);
    chk("pt_rd", last_rd, 32'hDEAD_BEEF);
    cyc(0, TX, 1, 32'h99, 0, 0);
    chk("io_we", {31'b0, last_we}, 32'h0);
    cyc(0, 32'hFFFF_0010, 0, 0, 0, 32'hDEAD_BEEF);
    chk("io_hole", last_rd, 32'h0);
    cyc(0, TX, 0, 0, 0, 0);
    chk("tx_reads0", last_rd, 32'h0);
    cyc(0, 0, 0, 0, 1, 0);

    // Push / drain
    for (int i = 0; i < 3; i++) cyc(0, TX, 1, 32'h41 + i, 0, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("st_cnt3", last_rd, 32'h0000_0003);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("drain_vld", {31'b0, last_valid}, 32'h1);
      chk("drain_dat", {24'b0, last_data}, 32'h41 + i);
    end
    cyc(0, ST, 0, 0, 0, 0);
    chk("drained_vld", {31'b0, last_valid}, 32'h0);
    chk("drained_st", last_rd, 32'h2000_0000);

    // Full / overflow / clear / push+pop at full
    for (int i = 0; i < 9; i++) cyc(0, TX, 1, 32'h50 + i, 0, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("ovf_st", last_rd, 32'hC000_0008);
    cyc(0, ST, 1, 32'h1, 0, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("ovf_clr", last_rd, 32'h4000_0008);
    cyc(0, TX, 1, 32'h77, 1, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("full_pushpop", last_rd, 32'h4000_0008);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("ovf_drain", {24'b0, last_data}, (i < 7) ? 32'h51 + i : 32'h77);
    end

    // Reset mid-stream with overflow set
    for (int i = 0; i < 9; i++) cyc(0, TX, 1, 32'h60 + i, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("pre_rst_st", last_rd, 32'h8000_0005);
    cyc(1, ST, 0, 0, 0, 0);
    cyc(0, CY, 0, 0, 0, 0);
    chk("rst_cycle", last_rd, 32'h0);
    chk("rst_vld2", {31'b0, last_valid}, 32'h0);
    cyc(0, ST, 0, 0, 0, 0);
    chk("rst_st2", last_rd, 32'h2000_0000);

    // Cycle counter
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) cyc(0, CY, 0, 0, 0, 0);
    chk("cyc10", last_rd, HAS_CYC ? 32'd10 : 32'd0);
    cyc(0, CY, 1, 32'h5, 0, 0);
    cyc(0, CY, 0, 0, 0, 0);
    chk("cyc_clr0", last_rd, 32'h0);
    cyc(0, CY, 0, 0, 0, 0);
    chk("cyc_clr1", last_rd, HAS_CYC ? 32'd1 : 32'd0);
`ifdef MMIO_CYCLE_COUNTER_EN
    dut.cycle = 32'hFFFF_FFFF;
    m_cyc     = 32'hFFFF_FFFF;
    cyc(0, CY, 0, 0, 0, 0);
    chk("cyc_max", last_rd, 32'hFFFF_FFFF);
    cyc(0, CY, 0, 0, 0, 0);
    chk("cyc_wrap", last_rd, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0:       a = {16'h0000, 16'($urandom)};
        1, 2:    a = TX;
        3:       a = ST;
        4:       a = CY;
        default: a = 32'hFFFF_000C;
      endcase
      cyc(($urandom_range(0, 63) == 0), a, 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
